// File: rtl/cpu_irq_pkg.sv
// Shared definitions for the CPU external-interrupt path.
//
// Contents:
//   NUM_EXT_IRQ - number of external interrupt lines (CP0 Cause IP[7:2]).
//   FILT_CNT_W  - width of each line's glitch-filter counter.
//   irq_vec_t   - one bit per external interrupt line.
package cpu_irq_pkg;

    localparam int NUM_EXT_IRQ = 6;
    localparam int FILT_CNT_W  = 4;

    typedef logic [NUM_EXT_IRQ-1:0] irq_vec_t;

endpackage

// File: rtl/irq_line_filter.sv
// One external interrupt line: synchroniser chain followed by a glitch filter.
//
// Ports:
//   clk       in  - sole clock.
//   resetn    in  - asynchronous, active-low reset.
//   irq_raw   in  - asynchronous external request, active high.
//   filt      out - filtered, clock-aligned level (registered).
//   filt_dly  out - filt delayed by one cycle (registered), for edge detection.
module irq_line_filter
    import cpu_irq_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 4
) (
    input  logic clk,
    input  logic resetn,
    input  logic irq_raw,
    output logic filt,
    output logic filt_dly
);

    localparam logic [FILT_CNT_W-1:0] CNT_MAX = FILT_CNT_W'(FILTER_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [FILT_CNT_W-1:0]  cnt_q, cnt_d;
    logic                   filt_q, filt_d;
    logic                   filt_dly_q, filt_dly_d;
    logic                   sync_out;

    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], irq_raw};
        sync_out   = sync_q[SYNC_STAGES-1];
        filt_d     = filt_q;
        filt_dly_d = filt_q;
        // Counter only runs while the synchronised input disagrees with the
        // filtered value; any agreement restarts it, so short pulses vanish.
        cnt_d      = '0;
        if (sync_out != filt_q) begin
            if (cnt_q == CNT_MAX) begin
                filt_d = sync_out;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q     <= '0;
            cnt_q      <= '0;
            filt_q     <= 1'b0;
            filt_dly_q <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            cnt_q      <= cnt_d;
            filt_q     <= filt_d;
            filt_dly_q <= filt_dly_d;
        end
    end

    assign filt     = filt_q;
    assign filt_dly = filt_dly_q;

endmodule

// File: rtl/irq_input_conditioner.sv
// Conditions the external interrupt lines feeding CP0 Cause IP[7:2].
// Each line is synchronised and glitch-filtered; lines selected by EDGE_MASK
// latch rising edges until cleared, the others follow the filtered level.
//
// Ports:
//   clk          in  - sole clock.
//   resetn       in  - asynchronous, active-low reset.
//   irq_raw      in  - asynchronous external requests, active high.
//   clear_valid  in  - single-cycle clear strobe.
//   clear_mask   in  - edge-latched lines to clear when clear_valid is high.
//   irq_pending  out - registered pending vector to CP0 externalInterrupt[15:10].
//   irq_any      out - registered OR of irq_pending, cycle-aligned with it.
module irq_input_conditioner
    import cpu_irq_pkg::*;
#(
    parameter int                 NUM_IRQ       = NUM_EXT_IRQ,
    parameter int                 SYNC_STAGES   = 2,
    parameter int                 FILTER_CYCLES = 4,
    parameter logic [NUM_IRQ-1:0] EDGE_MASK     = '0
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [NUM_IRQ-1:0] irq_raw,
    input  logic               clear_valid,
    input  logic [NUM_IRQ-1:0] clear_mask,
    output logic [NUM_IRQ-1:0] irq_pending,
    output logic               irq_any
);

    logic [NUM_IRQ-1:0] filt;
    logic [NUM_IRQ-1:0] filt_dly;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic               any_q, any_d;

    for (genvar g = 0; g < NUM_IRQ; g++) begin : g_line
        irq_line_filter #(
            .SYNC_STAGES  (SYNC_STAGES),
            .FILTER_CYCLES(FILTER_CYCLES)
        ) u_filter (
            .clk     (clk),
            .resetn  (resetn),
            .irq_raw (irq_raw[g]),
            .filt    (filt[g]),
            .filt_dly(filt_dly[g])
        );
    end

    always_comb begin
        pending_d = pending_q;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (!EDGE_MASK[i]) begin
                pending_d[i] = filt[i];
            end else if (filt[i] && !filt_dly[i]) begin
                // Set wins over a simultaneous clear so a new edge is never lost.
                pending_d[i] = 1'b1;
            end else if (clear_valid && clear_mask[i]) begin
                pending_d[i] = 1'b0;
            end
        end
        // Derived from the next-state vector so irq_any tracks irq_pending exactly.
        any_d = |pending_d;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pending_q <= '0;
            any_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            any_q     <= any_d;
        end
    end

    assign irq_pending = pending_q;
    assign irq_any     = any_q;

endmodule

// File: tb/tb_irq_input_conditioner.sv
// Directed bench for irq_input_conditioner with line 5 edge-latched and the
// remaining lines level-sensitive, default sync depth and filter length.
module tb_irq_input_conditioner;

    logic       clk;
    logic       resetn;
    logic [5:0] irq_raw;
    logic       clear_valid;
    logic [5:0] clear_mask;
    logic [5:0] irq_pending;
    logic       irq_any;

    int n_pass;
    int n_total;

    typedef struct {
        logic [5:0] raw;
        logic       cv;
        logic [5:0] cm;
        logic [5:0] exp_pend;
        string      name;
    } vec_t;

    vec_t vecs[$];

    irq_input_conditioner #(
        .NUM_IRQ      (6),
        .SYNC_STAGES  (2),
        .FILTER_CYCLES(4),
        .EDGE_MASK    (6'b100000)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .irq_raw    (irq_raw),
        .clear_valid(clear_valid),
        .clear_mask (clear_mask),
        .irq_pending(irq_pending),
        .irq_any    (irq_any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [5:0] act, input logic [5:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Check both outputs; irq_any must always be the OR of the expected vector.
    task automatic chk_out(input string name, input logic [5:0] exp);
        chk({name, ".pending"}, irq_pending, exp);
        chk({name, ".any"}, {5'b0, irq_any}, {5'b0, |exp});
    endtask

    task automatic add(input string name, input logic [5:0] raw, input logic cv,
                       input logic [5:0] cm, input logic [5:0] exp);
        vec_t v;
        v.name = name; v.raw = raw; v.cv = cv; v.cm = cm; v.exp_pend = exp;
        vecs.push_back(v);
    endtask

    // Inputs are applied #1 after an edge; outputs checked #1 after the next edge.
    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        resetn = 1'b0;
        irq_raw = '0;
        clear_valid = 1'b0;
        clear_mask = '0;

        // Level latency on line 2: raw high before edges 0..19.
        for (int n = 0; n < 30; n++)
            add("level_lat", (n < 20) ? 6'b000100 : 6'b0, 1'b0, 6'b0,
                (n >= 6 && n < 26) ? 6'b000100 : 6'b0);
        // 3-cycle glitch on line 0: rejected.
        for (int n = 0; n < 14; n++)
            add("glitch3", (n < 3) ? 6'b000001 : 6'b0, 1'b0, 6'b0, 6'b0);
        // 4-cycle pulse on line 0: passes through for exactly 4 cycles.
        for (int n = 0; n < 14; n++)
            add("pulse4", (n < 4) ? 6'b000001 : 6'b0, 1'b0, 6'b0,
                (n >= 6 && n < 10) ? 6'b000001 : 6'b0);
        // Edge latch on line 5: 10-cycle pulse, stays pending, other-line clear
        // at n=20 does nothing, then clear on line 5 at n=25.
        for (int n = 0; n < 25; n++)
            add("edge_latch", (n < 10) ? 6'b100000 : 6'b0, (n == 20), 6'b011111,
                (n >= 6) ? 6'b100000 : 6'b0);
        add("edge_clear", 6'b0, 1'b1, 6'b100000, 6'b0);
        for (int n = 0; n < 3; n++)
            add("edge_idle", 6'b0, 1'b0, 6'b0, 6'b0);
        // Collision: clear line 5 (and level line 2) in the cycle the edge sets;
        // a later clear of level line 2 while high is ignored.
        for (int n = 0; n < 30; n++)
            add("collide", ((n < 10) ? 6'b100000 : 6'b0) | ((n < 20) ? 6'b000100 : 6'b0),
                (n == 6 || n == 10), (n == 6) ? 6'b100100 : 6'b000100,
                ((n >= 6) ? 6'b100000 : 6'b0) | ((n >= 6 && n < 26) ? 6'b000100 : 6'b0));
        add("collide_clear", 6'b0, 1'b1, 6'b100000, 6'b0);
        add("collide_idle", 6'b0, 1'b0, 6'b0, 6'b0);

        // Initial reset, released away from the clock edge.
        step();
        step();
        chk_out("reset_hold", 6'b0);
        resetn = 1'b1;
        for (int n = 0; n < 10; n++) begin
            step();
            chk_out("post_reset", 6'b0);
        end

        foreach (vecs[k]) begin
            irq_raw     = vecs[k].raw;
            clear_valid = vecs[k].cv;
            clear_mask  = vecs[k].cm;
            step();
            chk_out(vecs[k].name, vecs[k].exp_pend);
        end
        clear_valid = 1'b0;
        clear_mask  = '0;

        // Asynchronous reset mid-cycle with level and latched lines pending.
        irq_raw = 6'b100100;
        for (int n = 0; n < 8; n++) step();
        chk_out("pre_async", 6'b100100);
        #2;
        resetn = 1'b0;
        #1;
        chk_out("async_reset", 6'b0);
        irq_raw = '0;
        step();
        chk_out("async_hold", 6'b0);
        resetn = 1'b1;
        for (int n = 0; n < 10; n++) begin
            step();
            chk_out("async_post", 6'b0);
        end

        // Reset mid-filter: line 1 high from edge 0, reset pulsed after edge 2.
        irq_raw = 6'b000010;
        step();
        step();
        step();
        resetn = 1'b0;
        #2;
        chk_out("midfilt_rst", 6'b0);
        resetn = 1'b1;
        // Edge k is the next edge; pending rises after edge k+6.
        for (int n = 0; n < 7; n++) begin
            step();
            chk_out("midfilt", (n == 6) ? 6'b000010 : 6'b0);
        end
        irq_raw = '0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
